sequence_cracker: RTL and testbench
===================================

SEQUENCE_CRACKER -- requirements
Module: sequence_cracker

Interface
REQ-001 Parameter: PULSE_CYCLES, default 4, number of clk cycles the trigger is held high and then held low per transmitted bit.
REQ-002 Parameter: SETTLE_CYCLES, default 4, number of clk cycles waited after the trigger-low phase before match_in is sampled.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_btn  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a crack run.
REQ-006 match_in  input  4  detector match count (0..8) returned over GPIO.
REQ-007 gpio_out  output  2  [1]=trigger, [0]=data bit toward the detector's guess input.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high once the full 8-bit secret is recovered; held until start or reset.
REQ-010 fail  output  1  high when the detector response is inconsistent; held until start or reset.
REQ-011 found  output  8  recovered secret, MSB first (bit 7 = first secret bit).
REQ-012 bits_known  output  4  confirmed prefix length k (0..8).

Function
REQ-013 FSM states: IDLE, SETUP, TRIG_HI, TRIG_LO, SETTLE, EVAL, DONE, FAIL.
REQ-014 IDLE/DONE/FAIL + start: clear k, found, done and fail; load the probe (k=0, candidate 0, replay=0); go to SETUP.
REQ-015 start while busy is ignored.
REQ-016 SETUP, 1 cycle: drive gpio_out[0] with the current bit; keep gpio_out[1]=0.
REQ-017 TRIG_HI for PULSE_CYCLES, then TRIG_LO for PULSE_CYCLES: data stays stable through both phases.
REQ-018 SETTLE: wait SETTLE_CYCLES, then go to EVAL.
REQ-019 Probe mode: send one bit, candidate 0; EVAL with match_in >= k+1 -> found[7-k]=0, k=k+1.
REQ-020 Probe mode, match_in < k+1 -> enter replay mode.
REQ-021 Replay mode: send found[7], found[6] .. found[8-k] in order, then 1 (k+1 bits in total), each bit using SETUP..SETTLE; EVAL happens only after the last bit.
REQ-022 Replay EVAL, match_in >= k+1 -> found[7-k]=1, k=k+1.
REQ-023 Replay EVAL, match_in < k+1 -> FAIL.
REQ-024 After k increments to 8: match_in == 8 -> DONE; otherwise -> FAIL.
REQ-025 When k < 8 after an increment, start the next probe in SETUP.
REQ-026 busy=1 in SETUP, TRIG_HI, TRIG_LO, SETTLE and EVAL; busy=0 otherwise.
REQ-027 gpio_out[1]=1 only in TRIG_HI.
REQ-028 match_in is sampled only in EVAL.
REQ-029 match_in values above 8 are treated as 8.
REQ-030 Cycle counters are sized from max(PULSE_CYCLES, SETTLE_CYCLES).
REQ-031 Cost per bit: 2*PULSE_CYCLES+SETTLE_CYCLES+2 cycles.

Reset
REQ-032 reset_btn at any cycle, including mid-pulse: state=IDLE, gpio_out=2'b00, busy=0, done=0, fail=0, found=8'h00, bits_known=0, all counters 0.
REQ-033 After reset, no trigger edge is emitted until the next start.

Configuration
REQ-034 Macro SEQUENCE_CRACKER_STATS_EN defined: add output tx_count, 8 bits, counting trigger pulses sent in the current run; it clears on start and on reset and saturates at 255.
REQ-035 Macro SEQUENCE_CRACKER_STATS_EN undefined: tx_count port and its counter are absent, and all other behaviour is identical.

Verification
REQ-036 Detector model armed with secret 8'hA5, start -> done=1, found=8'hA5, fail=0, 26 trigger pulses (tx_count=26 with STATS).
REQ-037 Secret 8'h00 -> 8 pulses, done=1, found=8'h00; secret 8'hFF -> 44 pulses, done=1, found=8'hFF.
REQ-038 Detector secret not loaded (match_in held 0), start -> first replay EVAL gives fail=1, bits_known=0, busy=0, after 2 pulses.
REQ-039 Pulse shape: PULSE_CYCLES=4 -> trigger high for exactly 4 cycles; data is stable from the cycle before the rise through the end of TRIG_LO.
REQ-040 reset_btn asserted during TRIG_HI of the 5th pulse -> next cycle gpio_out=0, busy=0, found=0; a later start recovers 8'hA5 correctly.
REQ-041 start pulsed while busy -> no effect on the run; start pulsed in DONE -> run restarts with outputs cleared.

Source files
------------

// File: rtl/sequence_cracker.sv
// Recovers an 8-bit detector secret bit by bit through trigger/data GPIO pulses.
// Optional macro SEQUENCE_CRACKER_STATS_EN adds the tx_count trigger-pulse counter.
module sequence_cracker #(
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_btn,
    input  logic       start,
    input  logic [3:0] match_in,
    output logic [1:0] gpio_out,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] found,
    output logic [3:0] bits_known
`ifdef SEQUENCE_CRACKER_STATS_EN
    ,
    output logic [7:0] tx_count
`endif
);

    localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_TRIG_HI,
        ST_TRIG_LO,
        ST_SETTLE,
        ST_EVAL,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    k_q, k_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    found_q, found_d;
    logic          replay_q, replay_d;
    logic          accept;
    logic          cur_bit;
    logic [3:0]    match_sat;
    logic [4:0]    thr;

    always_ff @(posedge clk) begin
        if (reset_btn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            idx_q    <= '0;
            found_q  <= '0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            replay_q <= replay_d;
        end
    end

    // Replay resends the confirmed prefix from the MSB, then the guessed 1.
    always_comb begin
        cur_bit = 1'b0;
        if (replay_q) begin
            if (idx_q < k_q) cur_bit = found_q[3'(4'd7 - idx_q)];
            else             cur_bit = 1'b1;
        end
    end

    assign match_sat = (match_in > 4'd8) ? 4'd8 : match_in;
    assign thr       = {1'b0, k_q} + 5'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        idx_d    = idx_q;
        found_d  = found_q;
        replay_d = replay_q;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    accept   = 1'b1;
                    k_d      = '0;
                    idx_d    = '0;
                    found_d  = '0;
                    replay_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_TRIG_HI;
            end
            ST_TRIG_HI: begin
                if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_TRIG_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TRIG_LO: begin
                if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (replay_q && (idx_q != k_q)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_EVAL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EVAL: begin
                idx_d = '0;
                if ({1'b0, match_sat} >= thr) begin
                    found_d[3'(4'd7 - k_q)] = replay_q;
                    k_d      = k_q + 1'b1;
                    replay_d = 1'b0;
                    if (k_q == 4'd7) state_d = (match_sat == 4'd8) ? ST_DONE : ST_FAIL;
                    else             state_d = ST_SETUP;
                end else if (replay_q) begin
                    state_d = ST_FAIL;
                end else begin
                    replay_d = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        gpio_out    = 2'b00;
        case (state_q)
            ST_SETUP, ST_TRIG_LO, ST_SETTLE: begin
                busy        = 1'b1;
                gpio_out[0] = cur_bit;
            end
            ST_TRIG_HI: begin
                busy     = 1'b1;
                gpio_out = {1'b1, cur_bit};
            end
            ST_EVAL: busy = 1'b1;
            default: ;
        endcase
    end

    assign done       = (state_q == ST_DONE);
    assign fail       = (state_q == ST_FAIL);
    assign found      = found_q;
    assign bits_known = k_q;

`ifdef SEQUENCE_CRACKER_STATS_EN
    logic [7:0] tx_q;

    always_ff @(posedge clk) begin
        if (reset_btn)                               tx_q <= '0;
        else if (accept)                             tx_q <= '0;
        else if (state_q == ST_SETUP && tx_q != '1)  tx_q <= tx_q + 1'b1;
    end

    assign tx_count = tx_q;
`endif

endmodule

// File: tb/tb_sequence_cracker.sv
// Self-checking bench: behavioural prefix-matching detector plus arithmetic expectations.
module tb_sequence_cracker;

    localparam int P = 4;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset_btn;
    logic       start;
    logic [3:0] match_in;
    logic [1:0] gpio_out;
    logic       busy, done, fail;
    logic [7:0] found;
    logic [3:0] bits_known;
`ifdef SEQUENCE_CRACKER_STATS_EN
    logic [7:0] tx_count;
`endif

    sequence_cracker #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .reset_btn  (reset_btn),
        .start      (start),
        .match_in   (match_in),
        .gpio_out   (gpio_out),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .found      (found),
        .bits_known (bits_known)
`ifdef SEQUENCE_CRACKER_STATS_EN
        ,
        .tx_count   (tx_count)
`endif
    );

    always #5 clk = ~clk;

    // Detector: counts how many leading secret bits the received stream matches;
    // a wrong bit restarts it, and det_lim models a detector that stops advancing.
    logic [7:0] det_sec;
    int         det_lim;
    logic [3:0] det_over;
    logic       det_clr;
    int         p;
    int         npulse;
    logic       trig_prev;

    initial begin
        p = 0;
        npulse = 0;
        trig_prev = 1'b0;
    end

    always @(posedge clk) begin
        trig_prev <= gpio_out[1];
        if (det_clr) begin
            p      <= 0;
            npulse <= 0;
        end else if (gpio_out[1] && !trig_prev) begin
            npulse <= npulse + 1;
            if (p < 8 && gpio_out[0] === det_sec[7-p])
                p <= (p + 1 > det_lim) ? det_lim : p + 1;
            else
                p <= 0;
        end
    end

    assign match_in = (p == 8 && det_over != 4'd0) ? det_over : 4'(p);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_pulses(input logic [7:0] sec, input int lim);
        int n = 0;
        int kk = (lim < 8) ? lim : 8;
        for (int i = 0; i < kk; i++) n += sec[7-i] ? (i + 2) : 1;
        if (lim < 8) n += 1 + (lim + 1);
        return n;
    endfunction

    function automatic logic [7:0] exp_found(input logic [7:0] sec, input int lim);
        logic [7:0] f = '0;
        for (int i = 0; i < 8; i++) if (i < lim) f[7-i] = sec[7-i];
        return f;
    endfunction

    task automatic begin_run(input string tag, input logic [7:0] sec, input int lim,
                             input logic [3:0] ov);
        @(negedge clk);
        det_sec  = sec;
        det_lim  = lim;
        det_over = ov;
        start    = 1'b1;
        det_clr  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        det_clr = 1'b0;
        check({tag, ".start_busy"}, 32'(busy), 32'd1);
        check({tag, ".start_clear"}, {done, fail, found, bits_known}, 32'd0);
    endtask

    task automatic finish_run(input string tag, input logic [7:0] sec, input int lim,
                              input bit inject);
        int cyc = 0;
        while (!(done || fail) && cyc < 3000) begin
            start = (inject && cyc == 40) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, ".timeout"}, 32'(cyc < 3000), 32'd1);
        check({tag, ".done"}, 32'(done), 32'(lim >= 8));
        check({tag, ".fail"}, 32'(fail), 32'(lim < 8));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".found"}, 32'(found), 32'(exp_found(sec, lim)));
        check({tag, ".bits_known"}, 32'(bits_known), 32'((lim < 8) ? lim : 8));
        check({tag, ".pulses"}, 32'(npulse), 32'(exp_pulses(sec, lim)));
`ifdef SEQUENCE_CRACKER_STATS_EN
        check({tag, ".tx_count"}, 32'(tx_count), 32'(exp_pulses(sec, lim)));
`endif
    endtask

    initial begin
        logic d0;
        logic stable;
        int   w;
        int   hi;
        logic [7:0] rs;
        int   lim;

        reset_btn = 1'b1;
        start     = 1'b0;
        det_clr   = 1'b0;
        det_sec   = '0;
        det_lim   = 8;
        det_over  = '0;
        repeat (3) @(negedge clk);
        check("reset.gpio", 32'(gpio_out), 32'd0);
        check("reset.flags", {busy, done, fail}, 32'd0);
        check("reset.found", 32'(found), 32'd0);
        check("reset.bits_known", 32'(bits_known), 32'd0);
        reset_btn = 1'b0;

        // First run also checks the shape of the first pulse.
        begin_run("a5", 8'hA5, 8, 4'd0);
        d0 = gpio_out[0];
        w  = 0;
        while (!gpio_out[1] && w < 50) begin
            d0 = gpio_out[0];
            @(negedge clk);
            w++;
        end
        check("shape.rise_seen", 32'(w < 50), 32'd1);
        check("shape.data_before_rise", 32'(gpio_out[0]), 32'(d0));
        hi = 0;
        stable = 1'b1;
        while (gpio_out[1] && hi < 50) begin
            if (gpio_out[0] !== d0) stable = 1'b0;
            hi++;
            @(negedge clk);
        end
        check("shape.high_cycles", 32'(hi), 32'(P));
        repeat (P) begin
            if (gpio_out !== {1'b0, d0}) stable = 1'b0;
            @(negedge clk);
        end
        check("shape.data_stable", 32'(stable), 32'd1);
        finish_run("a5", 8'hA5, 8, 1'b0);

        // Restart from DONE; begin_run verifies outputs clear.
        begin_run("zero", 8'h00, 8, 4'd0);
        finish_run("zero", 8'h00, 8, 1'b1);

        begin_run("ones", 8'hFF, 8, 4'(9 + $urandom_range(0, 6)));
        finish_run("ones", 8'hFF, 8, 1'b1);

        begin_run("nosecret", 8'h5A, 0, 4'd0);
        finish_run("nosecret", 8'h5A, 0, 1'b0);

        rs  = 8'($urandom);
        lim = $urandom_range(1, 7);
        begin_run("stuck", rs, lim, 4'd0);
        finish_run("stuck", rs, lim, 1'b1);

        for (int i = 0; i < 5; i++) begin
            rs = 8'($urandom);
            begin_run("rand", rs, 8, ($urandom_range(0, 1) != 0) ? 4'(9 + $urandom_range(0, 6)) : 4'd0);
            finish_run("rand", rs, 8, ($urandom_range(0, 1) != 0));
        end

        // Reset during the high phase of the fifth pulse.
        begin_run("midreset", 8'hA5, 8, 4'd0);
        w = 0;
        while (!(npulse == 5 && gpio_out[1]) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("midreset.reached", 32'(w < 2000), 32'd1);
        check("midreset.found_before", 32'(found != 8'h00), 32'd1);
        reset_btn = 1'b1;
        @(posedge clk);
        #1;
        check("midreset.gpio", 32'(gpio_out), 32'd0);
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.found", 32'(found), 32'd0);
        check("midreset.bits_known", 32'(bits_known), 32'd0);
        check("midreset.done_fail", {done, fail}, 32'd0);
        @(negedge clk);
        reset_btn = 1'b0;
        stable = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (gpio_out[1] !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        check("midreset.quiet", 32'(stable), 32'd1);
        begin_run("after_reset", 8'hA5, 8, 4'd0);
        finish_run("after_reset", 8'hA5, 8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
